// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/control block: control-bundle bit map,
// forwarding select encodings and halt-drain FSM states.
package pipeline_hazard_ctrl_pkg;

    // Bundle order, MSB first: {is_jal,is_jalr,branch,mem_read,mem_to_reg,
    //                          mem_write,alu_src,write_enable,pc_to_reg,is_ecall}
    localparam int CTRL_IS_JAL       = 9;
    localparam int CTRL_IS_JALR      = 8;
    localparam int CTRL_BRANCH       = 7;
    localparam int CTRL_MEM_READ     = 6;
    localparam int CTRL_MEM_TO_REG   = 5;
    localparam int CTRL_MEM_WRITE    = 4;
    localparam int CTRL_ALU_SRC      = 3;
    localparam int CTRL_WRITE_ENABLE = 2;
    localparam int CTRL_PC_TO_REG    = 1;
    localparam int CTRL_IS_ECALL     = 0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN1,
        ST_DRAIN2,
        ST_HALTED
    } halt_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_unit.sv
// Combinational load-use stall detection and operand forwarding selects.
module hazard_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rs1,
    input  logic [REG_ADDR_W-1:0] i_ex_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_mem_valid,
    input  logic                  i_mem_wen,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_wb_valid,
    input  logic                  i_wb_wen,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    output logic                  o_load_use_stall,
    output logic [1:0]            o_forward_a,
    output logic [1:0]            o_forward_b
);

    logic w_mem_writes;
    logic w_wb_writes;

    // rd==0 excluded here, so x0 can never be forwarded
    assign w_mem_writes = i_mem_valid & i_mem_wen & (i_mem_rd != '0);
    assign w_wb_writes  = i_wb_valid  & i_wb_wen  & (i_wb_rd  != '0);

    assign o_load_use_stall = i_id_valid & i_ex_valid & i_ex_mem_read & (i_ex_rd != '0) &
                              ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                               (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

    always_comb begin
        o_forward_a = FWD_RF;
        o_forward_b = FWD_RF;
        if (w_mem_writes && (i_mem_rd == i_ex_rs1)) begin
            o_forward_a = FWD_MEM;
        end else if (w_wb_writes && (i_wb_rd == i_ex_rs1)) begin
            o_forward_a = FWD_WB;
        end
        if (w_mem_writes && (i_mem_rd == i_ex_rs2)) begin
            o_forward_b = FWD_MEM;
        end else if (w_wb_writes && (i_wb_rd == i_ex_rs2)) begin
            o_forward_b = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Control-path stage registers (ID/EX, EX/MEM, MEM/WB), stall/flush generation and
// the ecall halt-drain sequencer for the 5-stage RISC-V pipeline.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_redirect,
    input  logic                  ex_halt_cond,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  flush_ifid,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [CTRL_W-1:0]     mem_ctrl,
    output logic [CTRL_W-1:0]     wb_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  ex_valid,
    output logic                  mem_valid,
    output logic                  wb_valid,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  halted
);

    logic                  r_ex_valid, r_mem_valid, r_wb_valid;
    logic [CTRL_W-1:0]     r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
    logic [REG_ADDR_W-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd, r_mem_rd, r_wb_rd;
    halt_state_e           r_state;
    halt_state_e           w_state_nxt;
    logic                  w_stall, w_redirect, w_halt_trig, w_bubble;

    assign w_redirect  = ex_redirect & r_ex_valid;
    assign w_halt_trig = r_ex_valid & r_ex_ctrl[CTRL_IS_ECALL] & ex_halt_cond;

    hazard_fwd_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard_fwd (
        .i_id_valid      (id_valid),
        .i_id_rs1        (id_rs1),
        .i_id_rs2        (id_rs2),
        .i_id_uses_rs1   (id_uses_rs1),
        .i_id_uses_rs2   (id_uses_rs2),
        .i_ex_valid      (r_ex_valid),
        .i_ex_mem_read   (r_ex_ctrl[CTRL_MEM_READ]),
        .i_ex_rs1        (r_ex_rs1),
        .i_ex_rs2        (r_ex_rs2),
        .i_ex_rd         (r_ex_rd),
        .i_mem_valid     (r_mem_valid),
        .i_mem_wen       (r_mem_ctrl[CTRL_WRITE_ENABLE] | r_mem_ctrl[CTRL_PC_TO_REG]),
        .i_mem_rd        (r_mem_rd),
        .i_wb_valid      (r_wb_valid),
        .i_wb_wen        (r_wb_ctrl[CTRL_WRITE_ENABLE] | r_wb_ctrl[CTRL_PC_TO_REG]),
        .i_wb_rd         (r_wb_rd),
        .o_load_use_stall(w_stall),
        .o_forward_a     (forward_a),
        .o_forward_b     (forward_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt entry and draining freeze the front end; redirect outranks the load-use stall
    always_comb begin
        w_state_nxt = r_state;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        flush_ifid  = 1'b0;
        w_bubble    = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (w_halt_trig) begin
                    w_state_nxt = ST_DRAIN1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    flush_ifid  = 1'b1;
                    w_bubble    = 1'b1;
                end else if (w_redirect) begin
                    flush_ifid = 1'b1;
                    w_bubble   = 1'b1;
                end else if (w_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    w_bubble   = 1'b1;
                end
            end
            ST_DRAIN1, ST_DRAIN2, ST_HALTED: begin
                w_state_nxt = (r_state == ST_DRAIN1) ? ST_DRAIN2 : ST_HALTED;
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                flush_ifid  = 1'b1;
                w_bubble    = 1'b1;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= '0;
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_ex_rd     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_ctrl  <= '0;
            r_mem_rd    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_ctrl   <= '0;
            r_wb_rd     <= '0;
        end else begin
            r_wb_valid  <= r_mem_valid;
            r_wb_ctrl   <= r_mem_ctrl;
            r_wb_rd     <= r_mem_rd;
            r_mem_valid <= r_ex_valid;
            r_mem_ctrl  <= r_ex_ctrl;
            r_mem_rd    <= r_ex_rd;
            if (w_bubble) begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= '0;
                r_ex_rs1   <= '0;
                r_ex_rs2   <= '0;
                r_ex_rd    <= '0;
            end else begin
                r_ex_valid <= id_valid;
                r_ex_ctrl  <= id_ctrl;
                r_ex_rs1   <= id_rs1;
                r_ex_rs2   <= id_rs2;
                r_ex_rd    <= id_rd;
            end
        end
    end

    assign ex_valid  = r_ex_valid;
    assign ex_ctrl   = r_ex_ctrl;
    assign ex_rs1    = r_ex_rs1;
    assign ex_rs2    = r_ex_rs2;
    assign ex_rd     = r_ex_rd;
    assign mem_valid = r_mem_valid;
    assign mem_ctrl  = r_mem_ctrl;
    assign mem_rd    = r_mem_rd;
    assign wb_valid  = r_wb_valid;
    assign wb_ctrl   = r_wb_ctrl;
    assign wb_rd     = r_wb_rd;
    assign halted    = (r_state == ST_HALTED);

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sits downstream of the opcode decoder. Takes the decoded per-instruction control bundle from ID and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Generates stall, flush and forwarding selects.
- Sequences the ecall halt drain for the 5-stage pipelined RISC-V core.
- The datapath reads every stage's control bits from this block and from no other source.

Parameters:
REG_ADDR_W, 5, register index width
CTRL_W, 10, packed control bundle width (bit map in shared package)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_ctrl  in  CTRL_W  decoder bundle {is_jal,is_jalr,branch,mem_read,mem_to_reg,mem_write,alu_src,write_enable,pc_to_reg,is_ecall}
id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register fields; the decoder drives id_rs1=17 for ecall
id_uses_rs1, id_uses_rs2  in  1  operand actually read
ex_redirect  in  1  EX resolved taken branch/jal/jalr
ex_halt_cond  in  1  forwarded x17 value equals 10 (from EX)
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
flush_ifid  out  1  IF/ID loads a bubble next edge
ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W  stage control bundles
ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd  out  REG_ADDR_W  stage register fields
ex_valid, mem_valid, wb_valid  out  1  stage valid
forward_a, forward_b  out  2  00 = regfile, 10 = EX/MEM, 01 = MEM/WB
halted  out  1  sticky halt

Behaviour:
- Reset (asynchronous, reset==0): all valid, ctrl and reg fields = 0; state = RUN; halted = 0. Combinational outputs then evaluate to pc_write=1, ifid_write=1, flush_ifid=0, forward=00.
- writes_rd(stage) = valid & (ctrl.write_enable | ctrl.pc_to_reg) & rd != 0. JAL writes rd via pc_to_reg alone.
- Pipeline advance: every edge, MEM/WB <= EX/MEM and EX/MEM <= ID/EX, unconditionally. ID/EX <= ID inputs, or a bubble (valid=0, all ctrl=0, fields=0) when required below.
- Load-use stall, combinational: id_valid & ex_valid & ex_ctrl.mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Effect: pc_write=0, ifid_write=0, ID/EX loads a bubble.
  - Latency: exactly 1 cycle per load-use pair.
- Redirect: ex_redirect & ex_valid → flush_ifid=1 and ID/EX loads a bubble. Redirect overrides a simultaneous stall: pc_write=1 and the stall is suppressed.
- Forwarding, combinational, priority EX/MEM over MEM/WB:
  - forward_a=10 if writes_rd(MEM) & mem_rd==ex_rs1.
  - Else forward_a=01 if writes_rd(WB) & wb_rd==ex_rs1.
  - Else forward_a=00.
  - forward_b is the same against ex_rs2.
  - Register 0 never forwards.
- Halt FSM: RUN → DRAIN1 → DRAIN2 → HALTED.
  - RUN→DRAIN1 when ex_valid & ex_ctrl.is_ecall & ex_halt_cond; the same edge loads a bubble into ID/EX and IF/ID is flushed.
  - DRAIN1→DRAIN2 and DRAIN2→HALTED unconditionally.
  - In DRAIN*/HALTED: pc_write=0, ifid_write=0, flush_ifid=1, ID/EX takes only bubbles; ex_redirect and stall are ignored.
  - halted=1 only in HALTED; it stays set until reset.
- An ecall with ex_halt_cond=0 flows through as a no-op.
- Reset mid-drain returns to RUN with empty stages.

Decomposition:
- Shared package: control-bundle bit indices (CTRL_IS_JAL … CTRL_IS_ECALL), forward select encodings (FWD_RF, FWD_MEM, FWD_WB), FSM state encodings.
- One natural sub-module, hazard_fwd_unit: purely combinational stall and forwarding logic; the top keeps the stage registers and the FSM.

Test Plan:
1. Reset pulse mid-run with valid stages → all valid=0, ctrl=0, forward=00, pc_write=1, halted=0 immediately, without waiting for a clock edge.
2. lw x5 in EX, then add x6,x5,x7 in ID → one cycle with pc_write=0, ifid_write=0, ex_valid=0 next; then the add enters EX with forward_a=01.
3. add x3 in MEM and addi x3 in WB, EX reads rs1=3 → forward_a=10; same case with rd=0 → forward_a=00.
4. jal x1 in MEM (write_enable=0, pc_to_reg=1), EX reads x1 → forward_a=10.
5. Taken beq in EX while ID shows a load-use hazard → flush_ifid=1, pc_write=1, ID/EX bubble next edge.
6. ecall in EX with ex_halt_cond=1 → halted=0 for 2 edges, halted=1 on the 3rd edge and held. With ex_halt_cond=0 → halted stays 0 and the pipeline continues.
